// File: rtl/gpu_instruction_fifo.sv
// Instruction FIFO between the decoder and the draw engines: first-word-fall-through, valid/ready output.
// Optional registered almost-full flag enabled by defining GPU_INSTR_FIFO_AFULL_EN.
`ifndef WIDTH_BITS
`define WIDTH_BITS 10
`endif
`ifndef HEIGHT_BITS
`define HEIGHT_BITS 9
`endif
`ifndef CHANNEL_BITS
`define CHANNEL_BITS 8
`endif

module gpu_instruction_fifo #(
  parameter int DEPTH        = 8,
  parameter int AFULL_THRESH = DEPTH - 2,
  localparam int ADDR_BITS   = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     push_i,
  input  logic [3:0]               opcode_i,
  input  logic [`WIDTH_BITS-1:0]   x1_i,
  input  logic [`HEIGHT_BITS-1:0]  y1_i,
  input  logic [`WIDTH_BITS-1:0]   x2_i,
  input  logic [`HEIGHT_BITS-1:0]  y2_i,
  input  logic [`WIDTH_BITS-1:0]   rad_i,
  input  logic [2:0]               oct_i,
  input  logic [`CHANNEL_BITS-1:0] r_i,
  input  logic [`CHANNEL_BITS-1:0] g_i,
  input  logic [`CHANNEL_BITS-1:0] b_i,
  input  logic                     clear_i,
  input  logic                     ready_i,
  output logic                     valid_o,
  output logic [3:0]               opcode_o,
  output logic [`WIDTH_BITS-1:0]   x1_o,
  output logic [`HEIGHT_BITS-1:0]  y1_o,
  output logic [`WIDTH_BITS-1:0]   x2_o,
  output logic [`HEIGHT_BITS-1:0]  y2_o,
  output logic [`WIDTH_BITS-1:0]   rad_o,
  output logic [2:0]               oct_o,
  output logic [`CHANNEL_BITS-1:0] r_o,
  output logic [`CHANNEL_BITS-1:0] g_o,
  output logic [`CHANNEL_BITS-1:0] b_o,
  output logic [ADDR_BITS:0]       count_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     overflow_o,
  output logic                     afull_o
);

  localparam int CNT_W  = ADDR_BITS + 1;
  localparam int WORD_W = 4 + 3 * `WIDTH_BITS + 2 * `HEIGHT_BITS + 3 + 3 * `CHANNEL_BITS;

  logic [WORD_W-1:0]    mem_q [DEPTH];
  logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 overflow_q, overflow_d;
  logic                 full_s, empty_s, pop_s, push_acc_s, drop_s;
  logic [WORD_W-1:0]    wr_word_s;

  assign full_s     = (count_q == CNT_W'(DEPTH));
  assign empty_s    = (count_q == {CNT_W{1'b0}});
  assign pop_s      = !empty_s && ready_i;
  assign push_acc_s = push_i && (!full_s || pop_s);
  assign drop_s     = push_i && full_s && !pop_s;
  assign wr_word_s  = {opcode_i, x1_i, y1_i, x2_i, y2_i, rad_i, oct_i, r_i, g_i, b_i};

  // Next-state for pointers, occupancy and the sticky overflow flag; clear_i wins over push/pop.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (clear_i) begin
      wr_ptr_d   = {ADDR_BITS{1'b0}};
      rd_ptr_d   = {ADDR_BITS{1'b0}};
      count_d    = {CNT_W{1'b0}};
      overflow_d = 1'b0;
    end else begin
      if (push_acc_s) begin
        wr_ptr_d = wr_ptr_q + ADDR_BITS'(1'b1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + ADDR_BITS'(1'b1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_acc_s, pop_s})
        2'b10:   count_d = count_q + CNT_W'(1'b1);
        2'b01:   count_d = count_q - CNT_W'(1'b1);
        default: count_d = count_q;
      endcase
      overflow_d = overflow_q | drop_s;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr_q   <= {ADDR_BITS{1'b0}};
      rd_ptr_q   <= {ADDR_BITS{1'b0}};
      count_q    <= {CNT_W{1'b0}};
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Entry storage is deliberately not reset; head fields are only meaningful while valid_o is high.
  always_ff @(posedge clk) begin
    if (push_acc_s && !clear_i) begin
      mem_q[wr_ptr_q] <= wr_word_s;
    end else begin
      mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
    end
  end

  assign {opcode_o, x1_o, y1_o, x2_o, y2_o, rad_o, oct_o, r_o, g_o, b_o} = mem_q[rd_ptr_q];

  assign count_o    = count_q;
  assign full_o     = full_s;
  assign empty_o    = empty_s;
  assign valid_o    = !empty_s;
  assign overflow_o = overflow_q;

`ifdef GPU_INSTR_FIFO_AFULL_EN
  logic afull_q, afull_d;

  assign afull_d = (count_d >= CNT_W'(AFULL_THRESH));

  // Almost-full tracks the occupancy that count_q takes on the same edge.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      afull_q <= 1'b0;
    end else begin
      afull_q <= afull_d;
    end
  end

  assign afull_o = afull_q;
`else
  logic unused_afull_thresh_s;
  assign unused_afull_thresh_s = (AFULL_THRESH == 0);
  assign afull_o = 1'b0;
`endif

endmodule

// File: tb/tb_gpu_instruction_fifo.sv
// Scoreboard bench for gpu_instruction_fifo: expected words queued on accepted pushes, compared on pops.
`ifndef WIDTH_BITS
`define WIDTH_BITS 10
`endif
`ifndef HEIGHT_BITS
`define HEIGHT_BITS 9
`endif
`ifndef CHANNEL_BITS
`define CHANNEL_BITS 8
`endif

module tb_gpu_instruction_fifo;
  localparam int DEPTH = 8;
  localparam int WB = `WIDTH_BITS;
  localparam int HB = `HEIGHT_BITS;
  localparam int CB = `CHANNEL_BITS;

  typedef struct packed {
    logic [3:0]    op;
    logic [WB-1:0] x1;
    logic [HB-1:0] y1;
    logic [WB-1:0] x2;
    logic [HB-1:0] y2;
    logic [WB-1:0] rad;
    logic [2:0]    oct;
    logic [CB-1:0] r;
    logic [CB-1:0] g;
    logic [CB-1:0] b;
  } word_t;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic push_i = 1'b0, clear_i = 1'b0, ready_i = 1'b0;
  word_t in_w = '0;
  word_t head_w;
  logic valid_o, full_o, empty_o, overflow_o, afull_o;
  logic [3:0] count_o;

  word_t sb_q[$];
  logic  exp_ovf = 1'b0;
  int    n_pass = 0;
  int    n_checks = 0;

  always #5 clk = ~clk;

  gpu_instruction_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .n_rst(n_rst), .push_i(push_i),
    .opcode_i(in_w.op), .x1_i(in_w.x1), .y1_i(in_w.y1), .x2_i(in_w.x2), .y2_i(in_w.y2),
    .rad_i(in_w.rad), .oct_i(in_w.oct), .r_i(in_w.r), .g_i(in_w.g), .b_i(in_w.b),
    .clear_i(clear_i), .ready_i(ready_i), .valid_o(valid_o),
    .opcode_o(head_w.op), .x1_o(head_w.x1), .y1_o(head_w.y1), .x2_o(head_w.x2), .y2_o(head_w.y2),
    .rad_o(head_w.rad), .oct_o(head_w.oct), .r_o(head_w.r), .g_o(head_w.g), .b_o(head_w.b),
    .count_o(count_o), .full_o(full_o), .empty_o(empty_o), .overflow_o(overflow_o), .afull_o(afull_o)
  );

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic word_t rnd_word(input int x1);
    word_t w;
    w.op  = 4'($urandom);
    w.x1  = WB'(x1);
    w.y1  = HB'($urandom);
    w.x2  = WB'($urandom);
    w.y2  = HB'($urandom);
    w.rad = WB'($urandom);
    w.oct = 3'($urandom);
    w.r   = CB'($urandom);
    w.g   = CB'($urandom);
    w.b   = CB'($urandom);
    return w;
  endfunction

  // One clock of traffic; expectations come from the queue depth and the accept rules.
  task automatic xfer(input logic do_push, input word_t w, input logic do_ready);
    logic pop_e, acc_e;
    pop_e = do_ready && (sb_q.size() > 0);
    acc_e = do_push && ((sb_q.size() < DEPTH) || pop_e);
    push_i  = do_push;
    in_w    = w;
    ready_i = do_ready;
    #1;
    check_eq("valid_pre", {127'd0, valid_o}, {127'd0, sb_q.size() > 0});
    if (pop_e) check_eq("head", 128'(head_w), 128'(sb_q.pop_front()));
    if (acc_e) sb_q.push_back(w);
    if (do_push && !acc_e) exp_ovf = 1'b1;
    cyc();
    push_i  = 1'b0;
    ready_i = 1'b0;
    check_eq("count", 128'(count_o), 128'(sb_q.size()));
    check_eq("overflow", {127'd0, overflow_o}, {127'd0, exp_ovf});
  endtask

  task automatic check_flags(input string tag);
    check_eq({tag, "_empty"}, {127'd0, empty_o}, {127'd0, sb_q.size() == 0});
    check_eq({tag, "_full"},  {127'd0, full_o},  {127'd0, sb_q.size() == DEPTH});
    check_eq({tag, "_valid"}, {127'd0, valid_o}, {127'd0, sb_q.size() != 0});
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_count"}, 128'(count_o), 128'd0);
    check_eq({tag, "_empty"}, {127'd0, empty_o}, 128'd1);
    check_eq({tag, "_full"},  {127'd0, full_o}, 128'd0);
    check_eq({tag, "_valid"}, {127'd0, valid_o}, 128'd0);
    check_eq({tag, "_ovf"},   {127'd0, overflow_o}, 128'd0);
    check_eq({tag, "_afull"}, {127'd0, afull_o}, 128'd0);
  endtask

  task automatic drain();
    int n;
    n = sb_q.size();
    for (int i = 0; i < n; i++) xfer(1'b0, '0, 1'b1);
    check_flags("drained");
  endtask

  initial begin
    word_t w0;
    #12;
    check_reset("reset");
    @(negedge clk);
    n_rst = 1'b1;
    cyc();

    // Single word, full-scale colour; no same-cycle bypass.
    w0 = '0;
    w0.op = 4'b0100; w0.x1 = WB'(5); w0.y1 = HB'(7); w0.x2 = WB'(20); w0.y2 = HB'(30);
    w0.rad = WB'(3); w0.oct = 3'd2; w0.r = '1; w0.g = '1; w0.b = '1;
    xfer(1'b1, w0, 1'b0);
    check_flags("one");
    check_eq("one_head", 128'(head_w), 128'(w0));
    drain();

    // Fill, overflow, ordered drain.
    for (int i = 0; i < DEPTH; i++) xfer(1'b1, rnd_word(i), 1'b0);
    check_flags("fill");
    xfer(1'b1, rnd_word(8), 1'b0);
    check_flags("ovf");
    for (int i = 0; i < DEPTH; i++) begin
      check_eq("order_x1", 128'(head_w.x1), 128'(i));
      xfer(1'b0, '0, 1'b1);
    end
    check_flags("drain1");
    check_eq("ovf_sticky", {127'd0, overflow_o}, 128'd1);

    clear_i = 1'b1; cyc(); clear_i = 1'b0;
    exp_ovf = 1'b0;
    check_reset("clr0");

    // Full with simultaneous push and pop.
    for (int i = 0; i < DEPTH; i++) xfer(1'b1, rnd_word(10 + i), 1'b0);
    xfer(1'b1, rnd_word(99), 1'b1);
    check_flags("fullpp");
    for (int i = 0; i < DEPTH - 1; i++) xfer(1'b0, '0, 1'b1);
    check_eq("last_x1", 128'(head_w.x1), 128'd99);
    drain();

    // Empty with push and ready together.
    xfer(1'b1, rnd_word(42), 1'b1);
    check_flags("emptypp");
    drain();

    // Clear with 3 queued and overflow set; clear discards the same-cycle push.
    for (int i = 0; i < DEPTH + 1; i++) xfer(1'b1, rnd_word(20 + i), 1'b0);
    for (int i = 0; i < DEPTH - 3; i++) xfer(1'b0, '0, 1'b1);
    check_eq("pre_clr_cnt", 128'(count_o), 128'd3);
    push_i = 1'b1; in_w = rnd_word(77); clear_i = 1'b1;
    cyc();
    push_i = 1'b0; clear_i = 1'b0;
    sb_q.delete(); exp_ovf = 1'b0;
    check_reset("clr3");

    // Asynchronous reset mid-drain.
    for (int i = 0; i < 4; i++) xfer(1'b1, rnd_word(30 + i), 1'b0);
    xfer(1'b0, '0, 1'b1);
    ready_i = 1'b1;
    @(posedge clk);
    #2 n_rst = 1'b0;
    #1;
    check_reset("arst");
    ready_i = 1'b0;
    sb_q.delete();
    @(negedge clk);
    n_rst = 1'b1;
    cyc();
    check_reset("arst_rel");

`ifdef GPU_INSTR_FIFO_AFULL_EN
    for (int i = 0; i < 5; i++) xfer(1'b1, rnd_word(50 + i), 1'b0);
    check_eq("afull5", {127'd0, afull_o}, 128'd0);
    xfer(1'b1, rnd_word(55), 1'b0);
    check_eq("afull6", {127'd0, afull_o}, 128'd1);
    xfer(1'b0, '0, 1'b1);
    check_eq("afull_pop", {127'd0, afull_o}, 128'd0);
    drain();
`else
    xfer(1'b1, rnd_word(60), 1'b0);
    check_eq("afull_off", {127'd0, afull_o}, 128'd0);
    drain();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/gpu_instruction_fifo.md
Name: gpu_instruction_fifo

Overview:
- Buffers fully-decoded draw instructions between the instruction decoder and the rasterizer/draw engines.
- Each push captures one complete instruction word: opcode, x1, y1, x2, y2, rad, oct, r, g, b. The word is a snapshot of the decoder's registered outputs in the cycle push_i is high.
- The output side is first-word-fall-through with a valid/ready handshake, so the draw engines can stall without losing commands.
- Field widths come from `WIDTH_BITS, `HEIGHT_BITS and `CHANNEL_BITS in gpu_definitions.vh.

Parameters:
- DEPTH, 8, number of instruction entries; must be a power of two, minimum 2.
- ADDR_BITS, $clog2(DEPTH), pointer width; derived, not overridden.
- AFULL_THRESH, DEPTH-2, occupancy at or above which afull_o asserts; only used with the optional feature.

Ports:
- clk  in  1  system clock
- n_rst  in  1  asynchronous active-low reset
- push_i  in  1  write strobe from the decoder's push_instruction_o
- opcode_i  in  4  instruction opcode
- x1_i  in  `WIDTH_BITS  start x
- y1_i  in  `HEIGHT_BITS  start y
- x2_i  in  `WIDTH_BITS  end x
- y2_i  in  `HEIGHT_BITS  end y
- rad_i  in  `WIDTH_BITS  radius
- oct_i  in  3  arc octant
- r_i, g_i, b_i  in  `CHANNEL_BITS each  colour
- clear_i  in  1  synchronous flush
- ready_i  in  1  consumer accepts the head entry
- valid_o  out  1  head entry present
- opcode_o, x1_o, y1_o, x2_o, y2_o, rad_o, oct_o, r_o, g_o, b_o  out  same widths as inputs  head entry fields
- count_o  out  ADDR_BITS+1  current occupancy
- full_o  out  1  count_o == DEPTH
- empty_o  out  1  count_o == 0
- overflow_o  out  1  sticky flag: a push was dropped
- afull_o  out  1  almost full (optional feature)

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-low on n_rst.
- Reset values: read and write pointers = 0, count_o = 0, empty_o = 1, full_o = 0, valid_o = 0, overflow_o = 0, afull_o = 0.
- Storage: DEPTH-entry register array. Contents are not reset; head fields are don't-care while valid_o = 0.
- Output fields: driven combinationally from entry[rd_ptr].
- valid_o = !empty_o.
- Push accept: push_i && (!full_o || pop), where pop = valid_o && ready_i. On accept, write the word at wr_ptr and increment wr_ptr modulo DEPTH (natural wrap).
- Pop: on pop, increment rd_ptr modulo DEPTH.
- Latency: a push into an empty FIFO at edge N gives valid_o = 1 with that word on the outputs after edge N. The same-cycle combinational value is not bypassed.
- Count update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged when push and pop occur together.
- Full with simultaneous push and pop: both happen; count stays DEPTH; the new word lands in the freed slot.
- Empty with push and ready_i: no pop, because valid_o = 0. Push is accepted; count goes to 1.
- Push while full without pop: word dropped, pointers and count unchanged, overflow_o set at the next edge.
- overflow_o stays set until clear_i or reset.
- ready_i while empty: ignored; no pointer movement.
- clear_i: has priority over push and pop in the same cycle. At the next edge, pointers and count go to 0 and overflow_o is cleared. The push in that cycle is discarded.
- Reset mid-operation: asynchronous return to the reset values; queued instructions are lost.

Optional Feature:
- Macro: GPU_INSTR_FIFO_AFULL_EN.
- Defined: afull_o is registered. It is 1 when next-cycle count >= AFULL_THRESH, and updates on the same edge as count_o. Upstream uses it to hold off command acceptance.
- Undefined: afull_o is tied to 0 and AFULL_THRESH is unused; the port is still present.

Test Plan:
- Reset, then push one word (opcode 4'b0100, x1=5, y1=7, x2=20, y2=30, r=g=b=max) -> next cycle valid_o=1, count_o=1, all output fields match.
- Push DEPTH=8 words with x1=0..7, ready_i=0 -> full_o=1, count_o=8. A ninth push -> overflow_o=1, count_o stays 8. Then drain with ready_i=1 -> x1_o reads 0..7 in order, empty_o=1 after the 8th pop.
- Full FIFO, push x1=99 with ready_i=1 the same cycle -> count_o stays 8, overflow_o=0, and x1=99 appears last after draining.
- Empty FIFO, push_i=1 and ready_i=1 together -> count_o=1, valid_o=1 next cycle, no underflow.
- 3 entries queued plus overflow_o set, assert clear_i with push_i=1 -> next cycle count_o=0, empty_o=1, overflow_o=0. Assert n_rst low mid-drain -> outputs return to the reset values immediately.
- With GPU_INSTR_FIFO_AFULL_EN defined and DEPTH=8: push 5 words -> afull_o=0; 6th push -> afull_o=1; one pop -> afull_o=0.
